rgb_to_gray_stream: RTL and testbench

//   Streaming, parametrised RGB-to-grayscale converter: weighted sum R*cr + G*cg + B*cb,

---
 rtl/rgb_to_gray_stream_pkg.sv | 19 +
 rtl/rgb_to_gray_stream_if.sv | 35 +++
 rtl/rgb_to_gray_stream_slice.sv | 38 +++
 rtl/rgb_to_gray_stream.sv | 164 ++++++++++++++++
 tb/tb_rgb_to_gray_stream.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_to_gray_stream_pkg.sv
// rgb_to_gray_stream_pkg
//   Shared definitions for the RGB-to-grayscale stream converter:
//   default coefficients (5/9/2 of 16), the saturation counter width and
//   the helper that gives the right-shift applied to the weighted sum.
package rgb_to_gray_stream_pkg;

  localparam int CR_DEFAULT = 5;
  localparam int CG_DEFAULT = 9;
  localparam int CB_DEFAULT = 2;

  localparam int SAT_CNT_W = 16;

  // The weighted sum carries CH_W+COEF_W fractional-scaled bits; dropping the
  // low bits lines it up with the gray output width.
  function automatic int gray_shift(input int ch_w, input int coef_w, input int out_w);
    return ch_w + coef_w - out_w;
  endfunction

endpackage

// File: rtl/rgb_to_gray_stream_if.sv
// rgb_to_gray_stream_if
//   Pixel-in / gray-out stream bundle with valid/ready handshakes on both
//   sides and sof/eol frame tags.
//   master : upstream pixel source + downstream gray sink (drives s_*, m_ready)
//   slave  : the converter (drives s_ready, m_*)
interface rgb_to_gray_stream_if #(
  parameter int CH_W  = 4,
  parameter int OUT_W = 8
);

  logic             s_valid;
  logic             s_ready;
  logic [CH_W-1:0]  s_red;
  logic [CH_W-1:0]  s_green;
  logic [CH_W-1:0]  s_blue;
  logic             s_sof;
  logic             s_eol;

  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_gray;
  logic             m_sof;
  logic             m_eol;

  modport master (
    output s_valid, s_red, s_green, s_blue, s_sof, s_eol, m_ready,
    input  s_ready, m_valid, m_gray, m_sof, m_eol
  );

  modport slave (
    input  s_valid, s_red, s_green, s_blue, s_sof, s_eol, m_ready,
    output s_ready, m_valid, m_gray, m_sof, m_eol
  );

endinterface

// File: rtl/rgb_to_gray_stream_slice.sv
// gray_pipe_slice
//   Generic single-entry valid/ready register stage. Loads when empty or when
//   the downstream consumer takes the current word in the same cycle, so a
//   chain of slices runs at one word per clock without bubbles.
//   Ports:
//     clk, rst              clock, async active-high reset
//     in_valid/in_ready     upstream handshake, in_data payload
//     out_valid/out_ready   downstream handshake, out_data payload (registered)
module gray_pipe_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      // Data only moves with a real word; holding it otherwise keeps the
      // output quiet when the stage drains.
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/rgb_to_gray_stream.sv
// rgb_to_gray_stream
//   Streaming RGB-to-grayscale converter: gray = (R*cr + G*cg + B*cb) >> shift,
//   saturated to all ones. Two register stages (products, then gray) with
//   valid/ready backpressure; sof/eol ride along with each pixel.
//   Coefficients are run-time programmable via a one-cycle cfg_load strobe.
//   Build option: define GRAY_THRESH_EN to add the thresh input and the
//   registered m_bin = (m_gray >= thresh) output.
//   Ports:
//     clk, rst                  clock, async active-high reset
//     bus (slave)               s_* pixel input stream, m_* gray output stream
//     cfg_load, cfg_cr/cg/cb    coefficient update strobe and values
//     sat_cnt                   count of saturated outputs transferred (wraps)
//     thresh, m_bin             threshold compare (GRAY_THRESH_EN only)
module rgb_to_gray_stream
  import rgb_to_gray_stream_pkg::*;
#(
  parameter int CH_W   = 4,
  parameter int COEF_W = 4,
  parameter int OUT_W  = 8,
  parameter int CR_RST = CR_DEFAULT,
  parameter int CG_RST = CG_DEFAULT,
  parameter int CB_RST = CB_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  rgb_to_gray_stream_if.slave  bus,
  input  logic                 cfg_load,
  input  logic [COEF_W-1:0]    cfg_cr,
  input  logic [COEF_W-1:0]    cfg_cg,
  input  logic [COEF_W-1:0]    cfg_cb,
`ifdef GRAY_THRESH_EN
  input  logic [OUT_W-1:0]     thresh,
  output logic                 m_bin,
`endif
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  localparam int PROD_W = CH_W + COEF_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int SHIFT  = gray_shift(CH_W, COEF_W, OUT_W);
  localparam logic [SUM_W-1:0] GRAY_MAX = SUM_W'((1 << OUT_W) - 1);

  localparam int S1_W = 3 * PROD_W + 2;
`ifdef GRAY_THRESH_EN
  localparam int S2_W = OUT_W + 4;
`else
  localparam int S2_W = OUT_W + 3;
`endif

  // ---------------------------------------------------------------------
  // Coefficient registers. A pixel accepted in the cfg_load cycle samples
  // the products before the edge, so it naturally sees the old values.
  // ---------------------------------------------------------------------
  logic [COEF_W-1:0] coef_r;
  logic [COEF_W-1:0] coef_g;
  logic [COEF_W-1:0] coef_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_r <= COEF_W'(CR_RST);
      coef_g <= COEF_W'(CG_RST);
      coef_b <= COEF_W'(CB_RST);
    end else if (cfg_load) begin
      coef_r <= cfg_cr;
      coef_g <= cfg_cg;
      coef_b <= cfg_cb;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: per-channel products plus tags
  // ---------------------------------------------------------------------
  logic [PROD_W-1:0] pr_n;
  logic [PROD_W-1:0] pg_n;
  logic [PROD_W-1:0] pb_n;
  logic [S1_W-1:0]   s1_d;
  logic [S1_W-1:0]   s1_q;
  logic              v1;
  logic              rdy2;

  assign pr_n = PROD_W'(bus.s_red)   * PROD_W'(coef_r);
  assign pg_n = PROD_W'(bus.s_green) * PROD_W'(coef_g);
  assign pb_n = PROD_W'(bus.s_blue)  * PROD_W'(coef_b);
  assign s1_d = {pr_n, pg_n, pb_n, bus.s_sof, bus.s_eol};

  gray_pipe_slice #(.WIDTH(S1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.s_valid),
    .in_ready  (bus.s_ready),
    .in_data   (s1_d),
    .out_valid (v1),
    .out_ready (rdy2),
    .out_data  (s1_q)
  );

  logic [PROD_W-1:0] pr_q;
  logic [PROD_W-1:0] pg_q;
  logic [PROD_W-1:0] pb_q;
  logic              sof1_q;
  logic              eol1_q;

  assign {pr_q, pg_q, pb_q, sof1_q, eol1_q} = s1_q;

  // ---------------------------------------------------------------------
  // Stage 2: sum, scale, saturate
  // ---------------------------------------------------------------------
  logic [SUM_W-1:0] sum_n;
  logic [SUM_W-1:0] scaled_n;
  logic             sat_n;
  logic [OUT_W-1:0] gray_n;
  logic [S2_W-1:0]  s2_d;
  logic [S2_W-1:0]  s2_q;

  assign sum_n    = SUM_W'(pr_q) + SUM_W'(pg_q) + SUM_W'(pb_q);
  assign scaled_n = sum_n >> SHIFT;
  assign sat_n    = (scaled_n > GRAY_MAX);
  assign gray_n   = sat_n ? {OUT_W{1'b1}} : scaled_n[OUT_W-1:0];

  logic [OUT_W-1:0] gray_q;
  logic             sat_q;
  logic             sof_q;
  logic             eol_q;

`ifdef GRAY_THRESH_EN
  logic bin_n;
  // Compare against the saturated value so m_bin always agrees with m_gray.
  assign bin_n = (gray_n >= thresh);
  assign s2_d  = {gray_n, sat_n, sof1_q, eol1_q, bin_n};
  assign {gray_q, sat_q, sof_q, eol_q, m_bin} = s2_q;
`else
  assign s2_d  = {gray_n, sat_n, sof1_q, eol1_q};
  assign {gray_q, sat_q, sof_q, eol_q} = s2_q;
`endif

  // The saturation flag travels with the pixel so the counter only moves
  // when that pixel actually leaves.
  gray_pipe_slice #(.WIDTH(S2_W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .in_ready  (rdy2),
    .in_data   (s2_d),
    .out_valid (bus.m_valid),
    .out_ready (bus.m_ready),
    .out_data  (s2_q)
  );

  assign bus.m_gray = gray_q;
  assign bus.m_sof  = sof_q;
  assign bus.m_eol  = eol_q;

  // ---------------------------------------------------------------------
  // Saturation counter, wraps naturally at full scale
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (bus.m_valid && bus.m_ready && sat_q) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
module tb_rgb_to_gray_stream;
  import rgb_to_gray_stream_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_to_gray_stream_if #(.CH_W(4), .OUT_W(8)) bus();

  logic        cfg_load;
  logic [3:0]  cfg_cr;
  logic [3:0]  cfg_cg;
  logic [3:0]  cfg_cb;
  logic [15:0] sat_cnt;
`ifdef GRAY_THRESH_EN
  logic [7:0]  thresh;
  logic        m_bin;
`endif

  rgb_to_gray_stream #(
    .CH_W(4), .COEF_W(4), .OUT_W(8), .CR_RST(5), .CG_RST(9), .CB_RST(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cfg_load (cfg_load),
    .cfg_cr   (cfg_cr),
    .cfg_cg   (cfg_cg),
    .cfg_cb   (cfg_cb),
`ifdef GRAY_THRESH_EN
    .thresh   (thresh),
    .m_bin    (m_bin),
`endif
    .sat_cnt  (sat_cnt)
  );

  typedef struct packed {
    logic [7:0] gray;
    logic       sof;
    logic       eol;
    logic       bin;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;

  function automatic exp_t mk(input int gray, input bit sof, input bit eol, input bit bin);
    exp_t e;
    e.gray = 8'(gray);
    e.sof  = sof;
    e.eol  = eol;
    e.bin  = bin;
    return e;
  endfunction

  function automatic exp_t model(input int r, input int g, input int b,
                                 input int cr, input int cg, input int cb,
                                 input bit sof, input bit eol);
    int s;
    s = r * cr + g * cg + b * cb;
    return mk((s > 255) ? 255 : s, sof, eol, 1'b0);
  endfunction

  // Monitor: samples 1 time unit before each rising edge.
  logic stall_prev = 1'b0;
  exp_t held;
  exp_t got;
  exp_t e_mon;

  always @(negedge clk) begin
    #4;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      got = mk(int'(bus.m_gray), bus.m_sof, bus.m_eol, 1'b0);
`ifdef GRAY_THRESH_EN
      got.bin = m_bin;
`endif
      if (stall_prev) begin
        checks++;
        if (bus.m_valid !== 1'b1 || got !== held) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b gray=%0d sof=%0b eol=%0b, required valid=1 gray=%0d sof=%0b eol=%0b",
                   bus.m_valid, got.gray, got.sof, got.eol, held.gray, held.sof, held.eol);
        end
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got gray=%0d with no pixel outstanding, required none", got.gray);
        end else begin
          e_mon = exp_q.pop_front();
`ifndef GRAY_THRESH_EN
          got.bin = e_mon.bin;
`endif
          if (got !== e_mon) begin
            errors++;
            $display("FAIL out_pixel: got gray=%0d sof=%0b eol=%0b bin=%0b, required gray=%0d sof=%0b eol=%0b bin=%0b",
                     got.gray, got.sof, got.eol, got.bin, e_mon.gray, e_mon.sof, e_mon.eol, e_mon.bin);
          end
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held = got;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int r, input int g, input int b, input bit sof, input bit eol,
                      input exp_t e, input bit push);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_red   = 4'(r);
    bus.s_green = 4'(g);
    bus.s_blue  = 4'(b);
    bus.s_sof   = sof;
    bus.s_eol   = eol;
    for (int n = 0; n < 200 && !ok; n++) begin
      #1;
      if (bus.s_ready) begin
        if (push) exp_q.push_back(e);
        ok = 1'b1;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_eol   = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready=0 for 200 cycles, required acceptance");
    end
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    bus.m_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0 && !bus.m_valid) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pixels outstanding, required 0", exp_q.size());
  endtask

  task automatic load_cfg(input int cr, input int cg, input int cb);
    cfg_cr = 4'(cr);
    cfg_cg = 4'(cg);
    cfg_cb = 4'(cb);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required completion");
    $fatal(1);
  end

  initial begin
    int r, g, b;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_red = '0;
    bus.s_green = '0;
    bus.s_blue = '0;
    bus.s_sof = 1'b0;
    bus.s_eol = 1'b0;
    bus.m_ready = 1'b1;
    cfg_load = 1'b0;
    cfg_cr = '0;
    cfg_cg = '0;
    cfg_cb = '0;
`ifdef GRAY_THRESH_EN
    thresh = 8'd0;
`endif
    repeat (3) tick();
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_gray", int'(bus.m_gray), 0);
    chk("rst_tags", int'({bus.m_sof, bus.m_eol}), 0);
    chk("rst_sat_cnt", int'(sat_cnt), 0);
    rst = 1'b0;
    tick();
    chk("idle_s_ready", int'(bus.s_ready), 1);

    // 1: default coefficients, full white -> 75+135+30 = 240
    send(15, 15, 15, 1'b1, 1'b0, mk(240, 1, 0, 1), 1'b1);
    chk("lat_stage1_m_valid", int'(bus.m_valid), 0);
    tick();
    chk("lat_stage2_m_valid", int'(bus.m_valid), 1);
    chk("lat_stage2_gray", int'(bus.m_gray), 240);
    drain();
    chk("t1_sat_cnt", int'(sat_cnt), 0);

    // 2: unity-ish coefficients -> 675 saturates to 255
    load_cfg(15, 15, 15);
    send(15, 15, 15, 1'b0, 1'b1, mk(255, 0, 1, 1), 1'b1);
    drain();
    chk("t2_sat_cnt", int'(sat_cnt), 1);

    // 3: random stream against the model with random backpressure
    load_cfg(5, 9, 2);
    rand_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      r = $urandom_range(0, 15);
      g = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      send(r, g, b, (i == 0), (i % 8 == 7), model(r, g, b, 5, 9, 2, (i == 0), (i % 8 == 7)), 1'b1);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    chk("t3_sat_cnt", int'(sat_cnt), 1);

    // 4: cfg_load in the accept cycle -> old cr (5) for P, new cr (1) for P+1
    cfg_cr = 4'd1;
    cfg_cg = 4'd9;
    cfg_cb = 4'd2;
    cfg_load = 1'b1;
    send(4, 0, 0, 1'b0, 1'b0, mk(20, 0, 0, 0), 1'b1);
    cfg_load = 1'b0;
    send(4, 0, 0, 1'b0, 1'b0, mk(4, 0, 0, 0), 1'b1);
    drain();

    // 5: fill pipe with output stalled, then reset mid-stream
    bus.m_ready = 1'b0;
    send(15, 15, 15, 1'b0, 1'b0, '0, 1'b0);
    send(15, 15, 15, 1'b0, 1'b0, '0, 1'b0);
    chk("full_s_ready", int'(bus.s_ready), 0);
    chk("full_m_valid", int'(bus.m_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_m_valid", int'(bus.m_valid), 0);
    tick();
    tick();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    chk("post_rst_sat_cnt", int'(sat_cnt), 0);
    chk("post_rst_m_valid", int'(bus.m_valid), 0);
    send(15, 15, 15, 1'b1, 1'b1, mk(240, 1, 1, 1), 1'b1);
    drain();

`ifdef GRAY_THRESH_EN
    // 6: threshold at 128 with coefs 15/8/1
    load_cfg(15, 8, 1);
    thresh = 8'd128;
    send(7, 2, 6, 1'b0, 1'b0, mk(127, 0, 0, 0), 1'b1);
    send(8, 1, 0, 1'b0, 1'b0, mk(128, 0, 0, 1), 1'b1);
    send(12, 2, 4, 1'b0, 1'b0, mk(200, 0, 0, 1), 1'b1);
    drain();
`endif

    chk("queue_empty", exp_q.size(), 0);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
